// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with decoded sync, blank and
// strobe outputs. Line length can be shortened (hoffs), frame length extended
// (voffs) and odd/even frames lengthened by one line (interlace). All three
// controls are captured only at the frame boundary or at reset.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   ce_pix             pixel clock enable; counters advance only when high
//   hoffs, voffs       line shortening / frame lengthening
//   interlace          alternate 1-line frame lengthening on field=1
//   hcount, vcount     pixel and line counters
//   hs, vs             active-low syncs
//   hb, vb, de         blanks (active high) and display enable
//   line, frame        one-ce start-of-line / start-of-frame pulses
//   field              current interlace field
module video_timing_gen #(
  parameter int unsigned HCNT_W      = 9,
  parameter int unsigned VCNT_W      = 9,
  parameter int unsigned H_ACT_START = 1,
  parameter int unsigned H_ACT_END   = 256,
  parameter int unsigned HS_START    = 271,
  parameter int unsigned HS_END      = 295,
  parameter int unsigned H_TOTAL     = 336,
  parameter int unsigned V_ACT_START = 16,
  parameter int unsigned V_ACT_END   = 240,
  parameter int unsigned VS_START    = 250,
  parameter int unsigned VS_END      = 253,
  parameter int unsigned V_TOTAL     = 273,
  parameter int unsigned HOFFS_W     = 5,
  parameter int unsigned VOFFS_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce_pix,
  input  logic [HOFFS_W-1:0] hoffs,
  input  logic [VOFFS_W-1:0] voffs,
  input  logic               interlace,
  output logic [HCNT_W-1:0]  hcount,
  output logic [VCNT_W-1:0]  vcount,
  output logic               hs,
  output logic               vs,
  output logic               hb,
  output logic               vb,
  output logic               de,
  output logic               line,
  output logic               frame,
  output logic               field
);

  // Elaboration guard: the shortest line must still release hsync, and the
  // longest frame must fit the vertical counter.
  if ((H_TOTAL - ((2 ** HOFFS_W) - 1) <= HS_END) ||
      (V_TOTAL + (2 ** VOFFS_W) > (2 ** VCNT_W))) begin : g_param_check
    $error("video_timing_gen: timing parameters violate line/frame length limits");
  end

  logic [HOFFS_W-1:0] hoffs_l;
  logic [VOFFS_W-1:0] voffs_l;
  logic               interlace_l;

  logic [HCNT_W-1:0]  ht;
  logic [VCNT_W-1:0]  vt;
  logic               h_wrap;
  logic               f_wrap;
  logic [HCNT_W-1:0]  hcount_nx;
  logic [VCNT_W-1:0]  vcount_nx;
  logic               hb_nx;
  logic               hs_nx;
  logic               vb_nx;
  logic               vs_nx;

  // Next counter values and decodes; outputs are registered from these so
  // every decode lines up with the counter value it describes.
  always_comb begin
    ht        = HCNT_W'(H_TOTAL) - HCNT_W'(hoffs_l);
    vt        = VCNT_W'(V_TOTAL) + VCNT_W'(voffs_l) + VCNT_W'(interlace_l & field);
    // >= keeps the counters safe if they were ever beyond the wrap point.
    h_wrap    = (hcount >= (ht - HCNT_W'(1)));
    f_wrap    = h_wrap && (vcount >= (vt - VCNT_W'(1)));
    hcount_nx = h_wrap ? '0 : hcount + HCNT_W'(1);
    vcount_nx = vcount;
    if (f_wrap) begin
      vcount_nx = '0;
    end else if (h_wrap) begin
      vcount_nx = vcount + VCNT_W'(1);
    end
    hb_nx = !((hcount_nx >= HCNT_W'(H_ACT_START)) && (hcount_nx < HCNT_W'(H_ACT_END)));
    hs_nx = !((hcount_nx >= HCNT_W'(HS_START))    && (hcount_nx < HCNT_W'(HS_END)));
    vb_nx = !((vcount_nx >= VCNT_W'(V_ACT_START)) && (vcount_nx < VCNT_W'(V_ACT_END)));
    vs_nx = !((vcount_nx >= VCNT_W'(VS_START))    && (vcount_nx < VCNT_W'(VS_END)));
  end

  // Counter, decode and control-capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      hb          <= 1'b1;
      vb          <= 1'b1;
      de          <= 1'b0;
      line        <= 1'b0;
      frame       <= 1'b0;
      field       <= 1'b0;
      hoffs_l     <= hoffs;
      voffs_l     <= voffs;
      interlace_l <= interlace;
    end else if (ce_pix) begin
      hcount <= hcount_nx;
      vcount <= vcount_nx;
      hs     <= hs_nx;
      vs     <= vs_nx;
      hb     <= hb_nx;
      vb     <= vb_nx;
      de     <= !hb_nx && !vb_nx;
      line   <= h_wrap;
      frame  <= f_wrap;
      if (f_wrap) begin
        // Field follows the interlace mode of the frame that just ended.
        field       <= interlace_l ? !field : 1'b0;
        hoffs_l     <= hoffs;
        voffs_l     <= voffs;
        interlace_l <= interlace;
      end
    end else begin
      line  <= 1'b0;
      frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a scaled-down raster so many frames fit in
// a short run. A position-in-frame model predicts every output each cycle;
// directed scenarios add literal period/latency expectations.
module tb_video_timing_gen;

  localparam int unsigned HCNT_W      = 7;
  localparam int unsigned VCNT_W      = 5;
  localparam int unsigned H_ACT_START = 1;
  localparam int unsigned H_ACT_END   = 24;
  localparam int unsigned HS_START    = 28;
  localparam int unsigned HS_END      = 32;
  localparam int unsigned H_TOTAL     = 64;
  localparam int unsigned V_ACT_START = 2;
  localparam int unsigned V_ACT_END   = 12;
  localparam int unsigned VS_START    = 14;
  localparam int unsigned VS_END      = 16;
  localparam int unsigned V_TOTAL     = 18;
  localparam int unsigned HOFFS_W     = 5;
  localparam int unsigned VOFFS_W     = 3;
  localparam int unsigned BW          = HCNT_W + VCNT_W + 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ce_pix = 1'b1;
  logic [HOFFS_W-1:0] hoffs = '0;
  logic [VOFFS_W-1:0] voffs = '0;
  logic               interlace = 1'b0;
  logic [HCNT_W-1:0]  hcount;
  logic [VCNT_W-1:0]  vcount;
  logic               hs, vs, hb, vb, de, line, frame, field;

  video_timing_gen #(
    .HCNT_W(HCNT_W), .VCNT_W(VCNT_W),
    .H_ACT_START(H_ACT_START), .H_ACT_END(H_ACT_END),
    .HS_START(HS_START), .HS_END(HS_END), .H_TOTAL(H_TOTAL),
    .V_ACT_START(V_ACT_START), .V_ACT_END(V_ACT_END),
    .VS_START(VS_START), .VS_END(VS_END), .V_TOTAL(V_TOTAL),
    .HOFFS_W(HOFFS_W), .VOFFS_W(VOFFS_W)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .hoffs(hoffs), .voffs(voffs), .interlace(interlace),
    .hcount(hcount), .vcount(vcount),
    .hs(hs), .vs(vs), .hb(hb), .vb(vb), .de(de),
    .line(line), .frame(frame), .field(field)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Pixel-enable pattern: one ce every ce_div clocks.
  int ce_div = 1;
  int ce_cnt = 0;
  always @(negedge clk) begin
    ce_cnt = (ce_cnt + 1) % ce_div;
    ce_pix = (ce_cnt == 0);
  end

  // Model: p = ce ticks since start of frame; h/v derived by division.
  int  p = 0;
  int  lat_h = 0, lat_v = 0;
  bit  lat_i = 0, m_field = 0, m_line = 0, m_frame = 0;

  function automatic int m_ht();
    return int'(H_TOTAL) - lat_h;
  endfunction

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (reset) begin
      p = 0; lat_h = int'(hoffs); lat_v = int'(voffs); lat_i = interlace;
      m_field = 0; m_line = 0; m_frame = 0;
    end else if (ce_pix) begin
      int flen;
      flen = m_ht() * (int'(V_TOTAL) + lat_v + int'(lat_i & m_field));
      p = p + 1;
      if (p == flen) begin
        p = 0;
        m_field = lat_i ? !m_field : 1'b0;
        lat_h = int'(hoffs); lat_v = int'(voffs); lat_i = interlace;
      end
      m_line  = (p % m_ht() == 0);
      m_frame = (p == 0);
    end else begin
      m_line = 0; m_frame = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      int h, v;
      logic [BW-1:0] exp_b, act_b;
      bit e_hb, e_hs, e_vb, e_vs;
      h = p % m_ht();
      v = p / m_ht();
      e_hb = !(h >= int'(H_ACT_START) && h < int'(H_ACT_END));
      e_hs = !(h >= int'(HS_START) && h < int'(HS_END));
      e_vb = !(v >= int'(V_ACT_START) && v < int'(V_ACT_END));
      e_vs = !(v >= int'(VS_START) && v < int'(VS_END));
      exp_b = {HCNT_W'(h), VCNT_W'(v), e_hs, e_vs, e_hb, e_vb, !e_hb && !e_vb,
               m_line, m_frame, m_field};
      act_b = {hcount, vcount, hs, vs, hb, vb, de, line, frame, field};
      n_vec++;
      if (act_b !== exp_b) begin
        n_bad++;
        $display("FAIL cycle %0d outputs {h,v,hs,vs,hb,vb,de,line,frame,field}: got %h expected %h",
                 cyc, act_b, exp_b);
      end
    end
  end

  // Period measurement from the output pulses.
  int frame_at = 0, frame_per = 0, line_at = 0, line_per = 0;
  int hmax = 0, vmax = 0;
  always @(negedge clk) begin
    if (frame === 1'b1) begin frame_per = cyc - frame_at; frame_at = cyc; end
    if (line === 1'b1) begin line_per = cyc - line_at; line_at = cyc; end
    if (int'(hcount) > hmax) hmax = int'(hcount);
    if (int'(vcount) > vmax) vmax = int'(vcount);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (frame === 1'b1);
    end
    if (!seen) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_line();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (line === 1'b1);
    end
    if (!seen) chk("line_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pos(input int h, input int v);
    bit seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (int'(hcount) == h) && (int'(vcount) == v);
    end
    if (!seen) chk("pos_timeout", 32'd0, 32'd1);
  endtask

  logic [BW-1:0] rst_bundle;
  logic [HCNT_W-1:0] h_hold;

  initial begin
    // Reset state and first count.
    repeat (3) @(negedge clk);
    #1;
    rst_bundle = {hcount, vcount, hs, vs, hb, vb, de, line, frame, field};
    chk("reset_state", 32'(rst_bundle), 32'(20'h000F0));
    reset = 1'b0;
    @(negedge clk); #1;
    chk("first_hcount", 32'(hcount), 32'd1);
    chk("first_vcount", 32'(vcount), 32'd0);

    // Nominal timing.
    wait_pos(28, 0);
    chk("hs_low_at_28", 32'(hs), 32'd0);
    wait_frame();
    wait_frame();
    chk("frame_period_nominal", 32'(frame_per), 32'd1152);
    chk("line_period_nominal", 32'(line_per), 32'd64);

    // Shortened lines, longer frame; takes effect after the next wrap.
    hoffs = 5'd5; voffs = 3'd7;
    wait_frame();
    hmax = 0; vmax = 0;
    wait_frame();
    chk("frame_period_offs", 32'(frame_per), 32'd1475);
    chk("line_period_offs", 32'(line_per), 32'd59);
    chk("hcount_max_offs", 32'(hmax), 32'd58);
    chk("vcount_max_offs", 32'(vmax), 32'd24);

    // Mid-frame hoffs change is deferred to the next frame.
    hoffs = '0; voffs = '0;
    wait_frame();
    wait_pos(0, 5);
    hoffs = 5'd31;
    wait_line();
    chk("line_period_after_midframe_change", 32'(line_per), 32'd64);
    wait_frame();
    wait_line();
    chk("line_period_next_frame", 32'(line_per), 32'd33);
    hoffs = '0;
    wait_frame();
    wait_frame();

    // Interlace: alternating frame lengths and field toggle.
    interlace = 1'b1;
    wait_frame();
    wait_frame();
    chk("field_after_even", 32'(field), 32'd1);
    chk("frame_period_even", 32'(frame_per), 32'd1152);
    wait_frame();
    chk("field_after_odd", 32'(field), 32'd0);
    chk("frame_period_odd", 32'(frame_per), 32'd1216);
    interlace = 1'b0;
    wait_frame();
    wait_frame();
    chk("field_forced_zero", 32'(field), 32'd0);
    chk("frame_period_interlace_off", 32'(frame_per), 32'd1152);

    // Pixel enable 1 of 4.
    ce_div = 4;
    wait_line();
    wait_line();
    chk("line_period_ce4", 32'(line_per), 32'd256);
    h_hold = hcount;
    @(negedge clk); #1;
    chk("line_pulse_width", 32'(line), 32'd0);
    chk("hcount_hold_non_ce", 32'(hcount), 32'(h_hold));

    // Reset mid-frame.
    ce_div = 1;
    wait_pos(20, 7);
    reset = 1'b1;
    @(negedge clk); #1;
    rst_bundle = {hcount, vcount, hs, vs, hb, vb, de, line, frame, field};
    chk("midframe_reset_state", 32'(rst_bundle), 32'(20'h000F0));
    reset = 1'b0;
    @(negedge clk); #1;
    chk("resume_hcount", 32'(hcount), 32'd1);
    chk("resume_vcount", 32'(vcount), 32'd0);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
